// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage RISC-V pipeline.
// Resolves branches from the EX/MEM register, runs word loads/stores over a
// registered req/ack data-memory port guarded by a timeout watchdog, stalls
// the upstream stages while an access is outstanding, and loads the MEM/WB
// pipeline register for writeback.
module mem_stage #(
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned CNT_W       = 8,
    parameter bit          ALIGN_CHECK = 1'b1
) (
    input  logic        clk,
    input  logic        reset,

    // EX/MEM pipeline register
    input  logic        ex_mem_valid,
    input  logic [1:0]  wb_ctl,
    input  logic        branch,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] EX_MEM_NPC,
    input  logic        zero,
    input  logic [31:0] alu_result,
    input  logic [31:0] rdata2out,
    input  logic [4:0]  five_bit_muxout,

    // Branch resolution
    output logic        pc_src,
    output logic [31:0] branch_target,

    // Pipeline control
    output logic        mem_stall,
    output logic        mem_fault,

    // Data-memory port
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,

    // MEM/WB pipeline register
    output logic [1:0]  wb_ctlout,
    output logic [31:0] read_data,
    output logic [31:0] mem_alu_result,
    output logic [4:0]  mem_write_reg,
    output logic        mem_wb_valid
);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    // Last watchdog count before the access is abandoned.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] counter;

    logic is_mem;
    logic load_only;
    logic misaligned;
    logic at_limit;

    // A set memwrite dominates: an instruction flagged as both is a store.
    assign is_mem     = ex_mem_valid & (memread | memwrite);
    assign load_only  = memread & ~memwrite;
    assign misaligned = ALIGN_CHECK && (alu_result[1:0] != 2'b00);
    assign at_limit   = (counter == LAST_CNT);

    assign pc_src        = ex_mem_valid & branch & zero;
    assign branch_target = EX_MEM_NPC;

    // Stall upstream while an access is being issued or is still outstanding.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            S_IDLE:  mem_stall = is_mem & ~misaligned;
            S_WAIT:  mem_stall = ~dmem_ack & ~at_limit;
            default: mem_stall = 1'b0;
        endcase
    end

    // Access FSM, watchdog counter, memory port and MEM/WB register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            counter        <= '0;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            mem_fault      <= 1'b0;
            wb_ctlout      <= '0;
            read_data      <= '0;
            mem_alu_result <= '0;
            mem_write_reg  <= '0;
            mem_wb_valid   <= 1'b0;
        end else begin
            mem_fault <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (is_mem && !misaligned) begin
                        dmem_req     <= 1'b1;
                        dmem_we      <= memwrite;
                        dmem_addr    <= alu_result;
                        dmem_wdata   <= rdata2out;
                        counter      <= '0;
                        mem_wb_valid <= 1'b0;
                        state        <= S_WAIT;
                    end else if (is_mem) begin
                        // Misaligned: retire with writeback suppressed.
                        mem_fault      <= 1'b1;
                        wb_ctlout      <= '0;
                        read_data      <= '0;
                        mem_alu_result <= alu_result;
                        mem_write_reg  <= five_bit_muxout;
                        mem_wb_valid   <= 1'b1;
                    end else begin
                        wb_ctlout      <= wb_ctl;
                        read_data      <= '0;
                        mem_alu_result <= alu_result;
                        mem_write_reg  <= five_bit_muxout;
                        mem_wb_valid   <= ex_mem_valid;
                    end
                end

                S_WAIT: begin
                    if (dmem_ack) begin
                        // Ack takes priority over a coincident timeout.
                        wb_ctlout      <= wb_ctl;
                        read_data      <= load_only ? dmem_rdata : '0;
                        mem_alu_result <= alu_result;
                        mem_write_reg  <= five_bit_muxout;
                        mem_wb_valid   <= 1'b1;
                        dmem_req       <= 1'b0;
                        state          <= S_IDLE;
                    end else if (at_limit) begin
                        mem_fault      <= 1'b1;
                        wb_ctlout      <= '0;
                        read_data      <= '0;
                        mem_alu_result <= alu_result;
                        mem_write_reg  <= five_bit_muxout;
                        mem_wb_valid   <= 1'b1;
                        dmem_req       <= 1'b0;
                        state          <= S_IDLE;
                    end else begin
                        counter      <= counter + CNT_W'(1);
                        mem_wb_valid <= 1'b0;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed, table-driven bench for mem_stage (TIMEOUT=4).
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_mem_valid;
    logic [1:0]  wb_ctl;
    logic        branch, memread, memwrite, zero;
    logic [31:0] EX_MEM_NPC, alu_result, rdata2out;
    logic [4:0]  five_bit_muxout;
    logic        pc_src;
    logic [31:0] branch_target;
    logic        mem_stall, mem_fault;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        dmem_ack;
    logic [1:0]  wb_ctlout;
    logic [31:0] read_data, mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic        mem_wb_valid;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.TIMEOUT(4), .CNT_W(8), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .reset(reset),
        .ex_mem_valid(ex_mem_valid), .wb_ctl(wb_ctl), .branch(branch),
        .memread(memread), .memwrite(memwrite), .EX_MEM_NPC(EX_MEM_NPC),
        .zero(zero), .alu_result(alu_result), .rdata2out(rdata2out),
        .five_bit_muxout(five_bit_muxout),
        .pc_src(pc_src), .branch_target(branch_target),
        .mem_stall(mem_stall), .mem_fault(mem_fault),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_ctlout(wb_ctlout), .read_data(read_data),
        .mem_alu_result(mem_alu_result), .mem_write_reg(mem_write_reg),
        .mem_wb_valid(mem_wb_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [1:0]  wb;
        logic        br, rd, wr, zf;
        logic [31:0] npc, alu, wdat;
        logic [4:0]  rdst;
        logic        e_pc, e_stall, e_fault;
        logic [1:0]  e_wb;
        logic [31:0] e_alu;
        logic [4:0]  e_reg;
        logic        e_valid;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ex_mem_valid = 0; wb_ctl = 2'b00; branch = 0; memread = 0; memwrite = 0;
        EX_MEM_NPC = '0; zero = 0; alu_result = '0; rdata2out = '0;
        five_bit_muxout = '0; dmem_ack = 0; dmem_rdata = '0;
    endtask

    task automatic set_mem(input logic rd, input logic wr, input logic [1:0] wb,
                           input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rdst);
        ex_mem_valid = 1; wb_ctl = wb; branch = 0; memread = rd; memwrite = wr;
        zero = 0; alu_result = addr; rdata2out = wd; five_bit_muxout = rdst;
    endtask

    int stall_cycles;

    initial begin
        //       name          v  wb    br rd wr z  npc    alu    wdat  reg  pc st ft wb    alu    reg v
        vecs[0] = '{"alu_op",    1, 2'b10, 0, 0, 0, 0, 32'h0,  32'h10,  32'h0, 5'd5, 0, 0, 0, 2'b10, 32'h10,  5'd5, 1};
        vecs[1] = '{"br_taken",  1, 2'b00, 1, 0, 0, 1, 32'h40, 32'h0,   32'h0, 5'd0, 1, 0, 0, 2'b00, 32'h0,   5'd0, 1};
        vecs[2] = '{"br_nt",     1, 2'b00, 1, 0, 0, 0, 32'h40, 32'h4,   32'h0, 5'd0, 0, 0, 0, 2'b00, 32'h4,   5'd0, 1};
        vecs[3] = '{"bubble_br", 0, 2'b10, 1, 0, 0, 1, 32'h80, 32'h0,   32'h0, 5'd2, 0, 0, 0, 2'b10, 32'h0,   5'd2, 0};
        vecs[4] = '{"misal_ld",  1, 2'b11, 0, 1, 0, 0, 32'h0,  32'h102, 32'h0, 5'd7, 0, 0, 1, 2'b00, 32'h102, 5'd7, 1};
        vecs[5] = '{"misal_st",  1, 2'b00, 0, 0, 1, 0, 32'h0,  32'h201, 32'h5, 5'd0, 0, 0, 1, 2'b00, 32'h201, 5'd0, 1};
        vecs[6] = '{"bubble_ld", 0, 2'b11, 0, 1, 0, 0, 32'h0,  32'h300, 32'h0, 5'd4, 0, 0, 0, 2'b11, 32'h300, 5'd4, 0};

        // Reset state
        idle_inputs();
        reset = 1;
        tick(); tick();
        chk("rst_req",   {31'd0, dmem_req},     32'd0);
        chk("rst_we",    {31'd0, dmem_we},      32'd0);
        chk("rst_addr",  dmem_addr,             32'd0);
        chk("rst_wdata", dmem_wdata,            32'd0);
        chk("rst_fault", {31'd0, mem_fault},    32'd0);
        chk("rst_valid", {31'd0, mem_wb_valid}, 32'd0);
        chk("rst_wb",    {30'd0, wb_ctlout},    32'd0);
        chk("rst_rdata", read_data,             32'd0);
        chk("rst_alu",   mem_alu_result,        32'd0);
        chk("rst_reg",   {27'd0, mem_write_reg}, 32'd0);
        reset = 0;

        // Single-cycle vectors in IDLE
        for (int unsigned i = 0; i < 7; i++) begin
            ex_mem_valid = vecs[i].valid; wb_ctl = vecs[i].wb; branch = vecs[i].br;
            memread = vecs[i].rd; memwrite = vecs[i].wr; zero = vecs[i].zf;
            EX_MEM_NPC = vecs[i].npc; alu_result = vecs[i].alu;
            rdata2out = vecs[i].wdat; five_bit_muxout = vecs[i].rdst;
            #1;
            chk({vecs[i].name, "_pc_src"}, {31'd0, pc_src},    {31'd0, vecs[i].e_pc});
            chk({vecs[i].name, "_target"}, branch_target,      vecs[i].npc);
            chk({vecs[i].name, "_stall"},  {31'd0, mem_stall}, {31'd0, vecs[i].e_stall});
            tick();
            chk({vecs[i].name, "_fault"},  {31'd0, mem_fault},    {31'd0, vecs[i].e_fault});
            chk({vecs[i].name, "_req"},    {31'd0, dmem_req},     32'd0);
            chk({vecs[i].name, "_wb"},     {30'd0, wb_ctlout},    {30'd0, vecs[i].e_wb});
            chk({vecs[i].name, "_rdata"},  read_data,             32'd0);
            chk({vecs[i].name, "_alu"},    mem_alu_result,        vecs[i].e_alu);
            chk({vecs[i].name, "_reg"},    {27'd0, mem_write_reg}, {27'd0, vecs[i].e_reg});
            chk({vecs[i].name, "_valid"},  {31'd0, mem_wb_valid}, {31'd0, vecs[i].e_valid});
        end

        // Load acked on the 4th WAIT cycle (coincides with watchdog limit: ack wins)
        idle_inputs();
        set_mem(1, 0, 2'b11, 32'h100, 32'h0, 5'd3);
        stall_cycles = 0;
        #1;
        if (mem_stall) stall_cycles++;
        tick();
        for (int unsigned w = 0; w < 3; w++) begin
            #1;
            if (mem_stall) stall_cycles++;
            chk("ld_req",    {31'd0, dmem_req},     32'd1);
            chk("ld_we",     {31'd0, dmem_we},      32'd0);
            chk("ld_addr",   dmem_addr,             32'h100);
            chk("ld_bubble", {31'd0, mem_wb_valid}, 32'd0);
            tick();
        end
        dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
        #1;
        chk("ld_ack_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        idle_inputs();
        chk("ld_stall_cnt", stall_cycles,          32'd4);
        chk("ld_rdata",     read_data,             32'hDEADBEEF);
        chk("ld_wb",        {30'd0, wb_ctlout},    32'd3);
        chk("ld_valid",     {31'd0, mem_wb_valid}, 32'd1);
        chk("ld_alu",       mem_alu_result,        32'h100);
        chk("ld_reg",       {27'd0, mem_write_reg}, 32'd3);
        chk("ld_req_drop",  {31'd0, dmem_req},     32'd0);
        chk("ld_no_fault",  {31'd0, mem_fault},    32'd0);

        // Store (memread also set -> treated as store), ack in first WAIT cycle
        set_mem(1, 1, 2'b00, 32'h104, 32'h12345678, 5'd0);
        stall_cycles = 0;
        #1;
        if (mem_stall) stall_cycles++;
        tick();
        chk("st_req",   {31'd0, dmem_req}, 32'd1);
        chk("st_we",    {31'd0, dmem_we},  32'd1);
        chk("st_addr",  dmem_addr,         32'h104);
        chk("st_wdata", dmem_wdata,        32'h12345678);
        dmem_ack = 1; dmem_rdata = 32'hFFFFFFFF;
        #1;
        if (mem_stall) stall_cycles++;
        tick();
        idle_inputs();
        chk("st_stall_cnt", stall_cycles,          32'd1);
        chk("st_rdata",     read_data,             32'd0);
        chk("st_valid",     {31'd0, mem_wb_valid}, 32'd1);
        chk("st_req_drop",  {31'd0, dmem_req},     32'd0);

        // Load never acked -> timeout after 4 WAIT cycles, late ack ignored
        set_mem(1, 0, 2'b11, 32'h200, 32'h0, 5'd9);
        tick();
        for (int unsigned w = 0; w < 3; w++) begin
            #1;
            chk("to_stall", {31'd0, mem_stall}, 32'd1);
            chk("to_fault", {31'd0, mem_fault}, 32'd0);
            tick();
        end
        #1;
        chk("to_stall_drop", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("to_fault_pulse", {31'd0, mem_fault},    32'd1);
        chk("to_req_drop",    {31'd0, dmem_req},     32'd0);
        chk("to_wb",          {30'd0, wb_ctlout},    32'd0);
        chk("to_valid",       {31'd0, mem_wb_valid}, 32'd1);
        chk("to_reg",         {27'd0, mem_write_reg}, 32'd9);
        idle_inputs();
        dmem_ack = 1; dmem_rdata = 32'hCAFEF00D;
        #1;
        chk("late_ack_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("late_ack_fault", {31'd0, mem_fault},    32'd0);
        chk("late_ack_req",   {31'd0, dmem_req},     32'd0);
        chk("late_ack_rdata", read_data,             32'd0);
        chk("late_ack_valid", {31'd0, mem_wb_valid}, 32'd0);
        dmem_ack = 0;

        // Reset asserted mid-access
        set_mem(1, 0, 2'b11, 32'h300, 32'h0, 5'd6);
        tick();
        chk("rw_req_up", {31'd0, dmem_req}, 32'd1);
        reset = 1;
        tick();
        chk("rw_req",   {31'd0, dmem_req},     32'd0);
        chk("rw_valid", {31'd0, mem_wb_valid}, 32'd0);
        chk("rw_addr",  dmem_addr,             32'd0);
        reset = 0;
        idle_inputs();
        dmem_ack = 1; dmem_rdata = 32'h11111111;
        #1;
        chk("rw_ack_stall", {31'd0, mem_stall}, 32'd0);
        tick();
        chk("rw_ack_rdata", read_data,             32'd0);
        chk("rw_ack_valid", {31'd0, mem_wb_valid}, 32'd0);
        chk("rw_ack_req",   {31'd0, dmem_req},     32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage RISC-V pipeline. It consumes the EX/MEM register outputs produced by the execute stage.
- Resolves branches (PCSrc, target) and runs load/store accesses on a req/ack data-memory port with a timeout watchdog.
- Stalls upstream while an access is pending, and drives the MEM/WB pipeline register toward writeback.

Parameters:
TIMEOUT, 255, cycles in WAIT without dmem_ack before the access is aborted (1..2^CNT_W-1)
CNT_W, 8, width of the watchdog counter
ALIGN_CHECK, 1, 1 = word accesses with alu_result[1:0]!=0 fault without issuing a request

Ports:
clk  input  1  clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
ex_mem_valid  input  1  EX/MEM holds a real instruction (0 = bubble)
wb_ctl  input  2  [1]=RegWrite, [0]=MemtoReg
branch  input  1  branch instruction
memread  input  1  load
memwrite  input  1  store
EX_MEM_NPC  input  32  branch target from EX adder
zero  input  1  ALU zero flag
alu_result  input  32  ALU result / memory address
rdata2out  input  32  store data
five_bit_muxout  input  5  destination register
pc_src  output  1  take branch
branch_target  output  32  equals EX_MEM_NPC
mem_stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
mem_fault  output  1  one-cycle pulse on misalign or timeout
dmem_req  output  1  access request, registered
dmem_we  output  1  1 = write, registered
dmem_addr  output  32  word address, registered
dmem_wdata  output  32  write data, registered
dmem_rdata  input  32  read data, valid with dmem_ack
dmem_ack  input  1  access complete
wb_ctlout  output  2  MEM/WB control
read_data  output  32  MEM/WB load data
mem_alu_result  output  32  MEM/WB ALU result
mem_write_reg  output  5  MEM/WB destination register
mem_wb_valid  output  1  MEM/WB holds a real instruction

Behaviour:
- Reset (synchronous, active-high; also mid-access): state=IDLE, counter=0. dmem_req, dmem_we, mem_fault and mem_wb_valid are 0. dmem_addr, dmem_wdata, wb_ctlout, read_data, mem_alu_result and mem_write_reg are 0. A dmem_ack arriving after reset is ignored.
- is_mem = ex_mem_valid & (memread | memwrite). If both memread and memwrite are set, the access is treated as a store.
- pc_src = ex_mem_valid & branch & zero (combinational). branch_target = EX_MEM_NPC.
- FSM states: IDLE, WAIT.
  - IDLE, no is_mem: MEM/WB captures the inputs at the next edge (read_data=0, valid=ex_mem_valid). Latency is 1 cycle.
  - IDLE, is_mem, aligned (or ALIGN_CHECK=0): mem_stall=1. At the edge: dmem_req<=1, dmem_we<=memwrite, dmem_addr<=alu_result, dmem_wdata<=rdata2out, counter<=0, MEM/WB valid<=0 (bubble), state<=WAIT.
  - IDLE, is_mem, misaligned: no request and mem_stall=0. mem_fault pulses 1 cycle. MEM/WB captures the instruction with wb_ctlout=0 and valid=1.
  - WAIT: dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until ack or timeout. mem_stall = ~dmem_ack.
  - WAIT with dmem_ack: at the edge, MEM/WB captures wb_ctl, alu_result, five_bit_muxout, valid=1, and read_data = memread&~memwrite ? dmem_rdata : 0. Also dmem_req<=0, state<=IDLE. Minimum load/store latency is 2 cycles.
  - WAIT without ack: counter increments. When counter==TIMEOUT-1 and no ack, that cycle drops mem_stall and pulses mem_fault. MEM/WB captures the instruction with wb_ctlout=0. dmem_req<=0, state<=IDLE.
  - Ack and timeout in the same cycle: ack wins; no fault.
- Upstream must hold the EX/MEM inputs stable while mem_stall=1. The block relies on that and does not re-latch them.
- dmem_ack seen in IDLE is ignored.
- Counter never wraps. It saturates at TIMEOUT-1 because the FSM exits at that point.

Test Plan:
- Reset then ALU op (valid=1, wb_ctl=2'b10, alu_result=0x10, reg=5, no mem) -> next cycle mem_wb_valid=1, mem_alu_result=0x10, mem_write_reg=5, read_data=0, mem_stall never 1.
- Load addr 0x100, ack with rdata=0xDEADBEEF 3 cycles after req -> dmem_req=1 with dmem_we=0 and dmem_addr=0x100 held constant; mem_stall high 4 cycles; then read_data=0xDEADBEEF, wb_ctlout=2'b11, valid=1.
- Store addr 0x104 data 0x12345678, ack in first WAIT cycle -> dmem_we=1, dmem_wdata=0x12345678, total stall 1 cycle, read_data=0.
- Branch with zero=1 and EX_MEM_NPC=0x40 -> pc_src=1, branch_target=0x40 same cycle. With zero=0 -> pc_src=0.
- TIMEOUT=4, load never acked -> mem_fault pulse after 4 WAIT cycles, dmem_req falls, wb_ctlout=0, state IDLE. A late ack is then ignored.
- Misaligned load addr 0x102 -> no dmem_req, mem_fault 1 cycle, no stall. Separately, reset asserted during WAIT -> dmem_req=0 next cycle, mem_wb_valid=0.
